// File: rtl/jtag_host_bridge.sv
// Host-side target of the JTAG port bridge: deserialises PC_Clk/PC_Data_In frames into host register reads/writes.
// Optional bus timeout enabled by defining JTAG_HOST_BRIDGE_TIMEOUT_EN.
module jtag_host_bridge #(
    parameter int unsigned ADDR_W  = 18,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              hclk,
    input  logic              rst,
    input  logic              PC_Clk,
    input  logic              PC_Data_In,
    input  logic              PC_Ready,
    input  logic              PC_Reset,
    output logic              PC_Data_Out,
    output logic              PC_Ack,
    output logic              PC_Error,
    output logic [ADDR_W-1:0] host_addr,
    output logic [DATA_W-1:0] host_wdata,
    output logic              host_wr,
    output logic              host_rd,
    input  logic [DATA_W-1:0] host_rdata,
    input  logic              host_ack
);

    localparam int unsigned SR_W  = ADDR_W + DATA_W;
    localparam int unsigned OSR_W = DATA_W + 1;
    localparam int unsigned CNT_W = 6;
    localparam int unsigned TMO_W = 8;
`ifdef JTAG_HOST_BRIDGE_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, SHIFT, DECODE, BUS, DONE} state_e;

    // Sync bit order: 0 PC_Clk, 1 PC_Data_In, 2 PC_Ready, 3 PC_Reset (idle levels 0,0,1,1)
    logic [3:0]        sync1_q, sync2_q;
    logic              clk_prev_q, rdy_prev_q;
    logic              pulse, rdy_fall, rdy_rise, jtag_rst;

    state_e            state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [OSR_W-1:0]  osr_q, osr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d, rd_q, rd_d, ack_q, ack_d, err_q, err_d;

    always_ff @(posedge hclk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 4'b1100;
            sync2_q    <= 4'b1100;
            clk_prev_q <= 1'b0;
            rdy_prev_q <= 1'b1;
        end else begin
            sync1_q    <= {PC_Reset, PC_Ready, PC_Data_In, PC_Clk};
            sync2_q    <= sync1_q;
            clk_prev_q <= sync2_q[0];
            rdy_prev_q <= sync2_q[2];
        end
    end

    assign pulse    = sync2_q[0] & ~clk_prev_q;
    assign rdy_fall = ~sync2_q[2] & rdy_prev_q;
    assign rdy_rise = sync2_q[2] & ~rdy_prev_q;
    assign jtag_rst = ~sync2_q[3];

    always_ff @(posedge hclk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            osr_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            osr_q   <= osr_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        osr_d   = osr_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        ack_d   = ack_q;
        err_d   = err_q;

        // Read-back register shifts on every pulse so phase-2 clocks walk rdata out MSB first
        if (pulse) begin
            osr_d = {osr_q[OSR_W-2:0], 1'b0};
        end

        if (jtag_rst) begin
            state_d = IDLE;
            sr_d    = '0;
            osr_d   = '0;
            cnt_d   = '0;
            tmo_d   = '0;
            wr_d    = 1'b0;
            rd_d    = 1'b0;
            ack_d   = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (rdy_fall) begin
                        state_d = SHIFT;
                        sr_d    = '0;
                        cnt_d   = '0;
                        ack_d   = 1'b0;
                        err_d   = 1'b0;
                    end
                end
                SHIFT: begin
                    if (pulse) begin
                        sr_d = {sr_q[SR_W-2:0], sync2_q[1]};
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    if (rdy_rise) begin
                        state_d = DECODE;
                    end
                end
                DECODE: begin
                    tmo_d = '0;
                    // 27-pulse frames carry an early dummy write clock that falls off the top
                    if (cnt_q == CNT_W'(SR_W) || cnt_q == CNT_W'(SR_W + 1)) begin
                        wr_d    = 1'b1;
                        addr_d  = sr_q[ADDR_W-1:0];
                        wdata_d = sr_q[SR_W-1:ADDR_W];
                        state_d = BUS;
                    end else if (cnt_q == CNT_W'(ADDR_W)) begin
                        rd_d    = 1'b1;
                        addr_d  = sr_q[ADDR_W-1:0];
                        state_d = BUS;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
                BUS: begin
                    if (host_ack) begin
                        wr_d    = 1'b0;
                        rd_d    = 1'b0;
                        ack_d   = 1'b1;
                        state_d = DONE;
                        if (rd_q) begin
                            osr_d = {host_rdata, 1'b0};
                        end
                    end else if (TMO_EN && tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        wr_d    = 1'b0;
                        rd_d    = 1'b0;
                        err_d   = 1'b1;
                        state_d = DONE;
                        if (rd_q) begin
                            osr_d = '0;
                        end
                    end else if (TMO_EN) begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign PC_Data_Out = osr_q[OSR_W-1];
    assign PC_Ack      = ack_q;
    assign PC_Error    = err_q;
    assign host_addr   = addr_q;
    assign host_wdata  = wdata_q;
    assign host_wr     = wr_q;
    assign host_rd     = rd_q;

endmodule

// File: doc/jtag_host_bridge.md
# jtag_host_bridge

Host-side target of the ECP3 JTAG port bridge. It deserialises the PC_Clk/PC_Data_In bit stream that the bridge gates out of TCK, decodes each frame into a single-byte register write or read on a simple host bus, and returns ack/error status and read data. It sits directly downstream of the JTAG bridge in the TSMAC eval design and runs entirely in the host clock domain; every JTAG-side input is treated as asynchronous.

## Interface
Parameters:
- ADDR_W, 18, host address width, equal to the number of address pulses per frame
- DATA_W, 8, host data width, equal to the number of write-data pulses per frame
- TIMEOUT, 255, maximum hclk cycles to wait for host_ack; 8-bit counter

Ports:
- hclk  in  1  host clock; only clock; must be at least 4x the TCK frequency
- rst  in  1  reset, asynchronous assert, active-high; synchronous deassert is supplied externally
- PC_Clk  in  1  gated shift pulse from the bridge; async
- PC_Data_In  in  1  serial frame data, MSB first; async
- PC_Ready  in  1  frame-complete level from the bridge; async
- PC_Reset  in  1  JTAG reset, active-low; async
- PC_Data_Out  out  1  serial read data back to the bridge
- PC_Ack  out  1  last transaction completed
- PC_Error  out  1  last transaction failed, either decode error or timeout
- host_addr  out  ADDR_W  register address
- host_wdata  out  DATA_W  write data
- host_wr  out  1  write strobe; held until host_ack
- host_rd  out  1  read strobe; held until host_ack
- host_rdata  in  DATA_W  read data, sampled when host_ack is high
- host_ack  in  1  single-cycle completion from the host

## Operation
- Input sync: 2-flop synchronisers on PC_Clk, PC_Data_In, PC_Ready and PC_Reset.
  - A rising edge of synced PC_Clk is a "pulse".
  - On each pulse, synced PC_Data_In shifts into a 26-bit shift register from the LSB.
- Pulse counter: 6 bits, saturating at 63.
- FSM states: IDLE, SHIFT, DECODE, BUS, DONE.
  - IDLE -> SHIFT on a falling edge of synced PC_Ready. This clears the shift register, the pulse counter, PC_Ack and PC_Error.
  - SHIFT counts pulses. SHIFT -> DECODE on a rising edge of synced PC_Ready.
  - DECODE classifies the frame by pulse count:
    - 26 or 27 pulses: write. wdata = sr[25:18], addr = sr[17:0]. A 27th pulse (the extra early write clock) is shifted out the top and ignored.
    - 18 pulses: read. addr = sr[17:0].
    - Any other count: decode error. Set PC_Error=1 and go to DONE.
  - BUS asserts host_wr or host_rd with host_addr and host_wdata stable until host_ack.
    - On host_ack: set PC_Ack=1. For a read, load the output shift register with {host_rdata, 1'b0}. Then go to DONE.
  - DONE holds PC_Ack/PC_Error until the next PC_Ready falling edge, then goes to SHIFT.
- Read-back path:
  - PC_Data_Out = MSB of the 9-bit output shift register.
  - On each pulse the register shifts left, filling with 0.
  - The 9 phase-2 pulses therefore present rdata[7] down to rdata[0], followed by 0.
- PC_Reset low (synced), from any state:
  - FSM returns to IDLE; drop host_wr/host_rd and clear both shift registers and the pulse counter.
  - PC_Ack and PC_Error are cleared.
  - A bus cycle aborted this way is not retried.
- A PC_Ready falling edge while in BUS is ignored; the block finishes the bus cycle first.

## Timing
- Reset values: PC_Data_Out=0, PC_Ack=0, PC_Error=0, host_addr=0, host_wdata=0, host_wr=0, host_rd=0; FSM=IDLE.
- Input latency: an async input change is seen internally 2-3 hclk later. The pulse edge-detect adds 1 hclk.
- Synced PC_Ready rise -> DECODE in 1 hclk -> host_wr/host_rd asserted on the next hclk. Total from the raw PC_Ready rise: 4-5 hclk.
- host_ack sampled high -> strobe low and PC_Ack=1 on the next hclk edge.
- PC_Data_Out is updated 1 hclk after each detected pulse. This gives a margin of at least 2 TCK before the bridge samples it at Count 4 onward.

## Configuration
- JTAG_HOST_BRIDGE_TIMEOUT_EN defined:
  - An 8-bit counter runs in BUS.
  - If TIMEOUT cycles elapse without host_ack: drop the strobe, set PC_Error=1, leave PC_Ack=0, and go to DONE. For a read, the output shift register loads 0.
- Undefined: BUS waits indefinitely for host_ack; PC_Error is set only by decode error.

## Test plan
- Write frame: 27 pulses carrying 1 dummy bit, then wdata 0xA5, then addr 0x12345; PC_Ready rises -> host_wr with host_addr=0x12345, host_wdata=0xA5; host_ack -> PC_Ack=1, PC_Error=0.
- Read frame: 18 pulses with addr 0x3FFFF; host_rdata=0x5C with ack -> host_rd seen; 9 phase-2 pulses give PC_Data_Out sequence 0,1,0,1,1,1,0,0 then 0.
- Malformed frame of 20 pulses -> no host strobe, PC_Error=1, PC_Ack=0.
- With JTAG_HOST_BRIDGE_TIMEOUT_EN and TIMEOUT=255, host_ack is never returned -> host_rd drops after 255 hclk, PC_Error=1; without the macro, host_rd stays high for 1000 cycles.
- PC_Reset low mid-shift after 10 pulses, then a full write frame -> the write decodes correctly with no residue from the first 10 bits.
- Reset asserted while host_wr is high -> all outputs return to 0 asynchronously; the first frame after reset behaves normally.
